uart_tx_arbiter: RTL



---
 rtl/uart_ctrl_pkg.sv | 30 +++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants and helpers for the UART transmit arbiter.
// Holds the controller state encoding, default timing values and a
// constant-foldable ceil(log2) used to size indices and counters.
package uart_ctrl_pkg;

  // Controller state encoding
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  // Default timing: GAP covers the transmitter's post-done delay states
  localparam int DEF_GAP_CYCLES     = 3;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // ceil(log2(value)); bounded loop so it folds at elaboration
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting at rr_ptr and wrapping modulo NUM_REQ;
// returns the first set request as a one-hot grant and an encoded index.
module rr_priority_pick
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [clog2(NUM_REQ)-1:0] grant_idx,
  output logic                      any_req
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] idx_s;

  // Walk from the farthest position back to rr_ptr so the nearest hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx_s     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s     = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      grant     = req[idx_s] ? (ONE_HOT_LSB << idx_s) : grant;
      grant_idx = req[idx_s] ? idx_s : grant_idx;
    end
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin controller sharing one UART transmitter among NUM_REQ
// parallel-byte requesters. Latches the winning byte onto the transmitter
// bus, fires one start_trig, waits for one_data_send (or times out), then
// holds an inter-frame gap before arbitrating again.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int data_width     = 8,
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [data_width-1:0]         tx_data_bus,
  output logic                          tx_start_trig,
  input  logic                          tx_one_data_send,
  output logic [clog2(NUM_REQ)-1:0]     grant_id,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          timeout_err
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0]    pick_grant_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_any_s;
  logic [IDX_W-1:0]      next_ptr_s;
  logic [data_width-1:0] picked_byte_s;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (pick_grant_s),
    .grant_idx (pick_idx_s),
    .any_req   (pick_any_s)
  );

  // Select the winner's byte through the one-hot grant
  always_comb begin
    picked_byte_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      picked_byte_s = pick_grant_s[i] ? req_data[i*data_width +: data_width] : picked_byte_s;
    end
  end

  // Pointer moves one past the requester just served, wrapping at NUM_REQ
  always_comb begin
    if (grant_id == LAST_IDX) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id + IDX_W'(1);
    end
  end

  // Ack and trigger decoded from the registered state and grant
  always_comb begin
    req_ack       = '0;
    tx_start_trig = 1'b0;
    busy          = (state_r != IDLE);
    if (state_r == START) begin
      req_ack[grant_id] = 1'b1;
      tx_start_trig     = 1'b1;
    end else begin
      req_ack       = '0;
      tx_start_trig = 1'b0;
    end
  end

  // Frame sequencing, wait/gap counter, data latch and sticky timeout flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      rr_ptr_r    <= '0;
      grant_id    <= '0;
      tx_data_bus <= '1;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            tx_data_bus <= picked_byte_s;
            grant_id    <= pick_idx_s;
            state_r     <= START;
          end
        end
        START: begin
          cnt_r   <= '0;
          state_r <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // done takes priority over a timeout on the same cycle
          if (tx_one_data_send) begin
            frame_done <= 1'b1;
            rr_ptr_r   <= next_ptr_s;
            cnt_r      <= '0;
            state_r    <= GAP;
          end else if (cnt_r == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            rr_ptr_r    <= next_ptr_s;
            cnt_r       <= '0;
            state_r     <= GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
